ascon_perm_engine: RTL and testbench

ASCON_PERM_ENGINE -- requirements
Module: ascon_perm_engine

---
 rtl/ascon_perm_engine.sv | 183 ++++++++++++++++++
 tb/tb_ascon_perm_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_engine.sv
// -----------------------------------------------------------------------------
// ascon_perm_engine
//
// Iterative Ascon-p permutation engine. A request carries a 320-bit state and
// a round count; the engine applies the last n = min(in_rounds, 12) rounds of
// Ascon-p (round indices 12-n .. 11), UROL rounds per clock, and presents the
// result until the consumer takes it.
//
// Parameters
//   UROL        rounds applied per clock (1 or 2)
//   MAX_ROUNDS  round ceiling (12); larger in_rounds values are clamped
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   request present on in_state / in_rounds
//   in_ready   engine idle and accepting a request
//   in_rounds  requested number of rounds (0..15)
//   in_state   input state, x0 in [319:256] down to x4 in [63:0]
//   out_valid  out_state holds a finished result
//   out_ready  consumer takes the result this cycle
//   out_state  result, same word layout as in_state
//   busy       engine is running or holding a result
// -----------------------------------------------------------------------------
module ascon_perm_engine #(
    parameter int UROL       = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_rounds,
    input  logic [319:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_IDX = 4'(MAX_ROUNDS);
    localparam bit         UNROLL2  = (UROL == 32'sd2);

    // Rotate a 64-bit lane right by amt positions.
    function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] amt);
        logic [127:0] dbl;
        dbl = {x, x} >> amt;
        return dbl[63:0];
    endfunction

    // One full Ascon round with round index idx.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        // round constant: upper nibble counts down while lower counts up
        x2 = x2 ^ {56'd0, 4'hF - idx, idx};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        // chi-like layer, every operand taken from the pre-update lanes
        t0 = x0 ^ (~x1 & x2);
        t1 = x1 ^ (~x2 & x3);
        t2 = x2 ^ (~x3 & x4);
        t3 = x3 ^ (~x4 & x0);
        t4 = x4 ^ (~x0 & x1);
        t1 = t1 ^ t0;
        t0 = t0 ^ t4;
        t3 = t3 ^ t2;
        t2 = ~t2;
        x0 = t0 ^ ror64(t0, 6'd19) ^ ror64(t0, 6'd28);
        x1 = t1 ^ ror64(t1, 6'd61) ^ ror64(t1, 6'd39);
        x2 = t2 ^ ror64(t2, 6'd1)  ^ ror64(t2, 6'd6);
        x3 = t3 ^ ror64(t3, 6'd10) ^ ror64(t3, 6'd17);
        x4 = t4 ^ ror64(t4, 6'd7)  ^ ror64(t4, 6'd41);
        return {x0, x1, x2, x3, x4};
    endfunction

    fsm_t         fsm_r;
    logic [3:0]   round_idx_r;
    logic [319:0] state_r;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;

    logic [319:0] round1_s;
    logic [319:0] round2_s;
    logic [319:0] next_state_s;
    logic [3:0]   next_idx_s;
    logic [3:0]   rounds_clamped_s;

    // Round datapath: one or two rounds per cycle; the second is bypassed
    // when only one round remains so odd counts finish exactly on index 12.
    always_comb begin
        round1_s = ascon_round(state_r, round_idx_r);
        round2_s = ascon_round(round1_s, round_idx_r + 4'd1);
        if (UNROLL2 && (round_idx_r <= (LAST_IDX - 4'd2))) begin
            next_state_s = round2_s;
            next_idx_s   = round_idx_r + 4'd2;
        end else begin
            next_state_s = round1_s;
            next_idx_s   = round_idx_r + 4'd1;
        end
    end

    // Clamp the requested round count to the permutation's round ceiling.
    always_comb begin
        if (in_rounds > LAST_IDX) begin
            rounds_clamped_s = LAST_IDX;
        end else begin
            rounds_clamped_s = in_rounds;
        end
    end

    // Control FSM with state register, round index and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= IDLE;
            round_idx_r <= 4'd0;
            state_r     <= 320'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (in_valid) begin
                        state_r     <= in_state;
                        round_idx_r <= LAST_IDX - rounds_clamped_s;
                        in_ready_r  <= 1'b0;
                        busy_r      <= 1'b1;
                        if (rounds_clamped_s == 4'd0) begin
                            fsm_r       <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            fsm_r       <= RUN;
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    state_r     <= next_state_s;
                    round_idx_r <= next_idx_s;
                    if (next_idx_s == LAST_IDX) begin
                        fsm_r       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_r       <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    fsm_r       <= IDLE;
                    round_idx_r <= 4'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_state = state_r;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// -----------------------------------------------------------------------------
// tb_ascon_perm_engine
//
// Drives one UROL=1 and one UROL=2 engine with identical requests. Expected
// results come from an array-based Ascon model; a per-engine queue holds the
// expected state and latency, and a negedge monitor pops and compares when an
// engine raises out_valid, applying random or scripted back-pressure.
// -----------------------------------------------------------------------------
module tb_ascon_perm_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic [3:0]   in_rounds;
    logic [319:0] in_state;

    logic         in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [319:0] out_state_a;
    logic         in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [319:0] out_state_b;

    ascon_perm_engine #(.UROL(1), .MAX_ROUNDS(12)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_rounds(in_rounds), .in_state(in_state), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_state(out_state_a), .busy(busy_a)
    );

    ascon_perm_engine #(.UROL(2), .MAX_ROUNDS(12)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_rounds(in_rounds), .in_state(in_state), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_state(out_state_b), .busy(busy_b)
    );

    logic         ov [2];
    logic         ir [2];
    logic         bz [2];
    logic [319:0] os [2];
    logic         ordy [2] = '{1'b0, 1'b0};

    assign ov[0] = out_valid_a;  assign ov[1] = out_valid_b;
    assign ir[0] = in_ready_a;   assign ir[1] = in_ready_b;
    assign bz[0] = busy_a;       assign bz[1] = busy_b;
    assign os[0] = out_state_a;  assign os[1] = out_state_b;
    assign out_ready_a = ordy[0];
    assign out_ready_b = ordy[1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [319:0] got, logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(logic [63:0] v, int a);
        return (v >> a) | (v << (64 - a));
    endfunction

    function automatic logic [319:0] model_perm(logic [319:0] s, int nr);
        logic [63:0] x [5];
        logic [63:0] t [5];
        int ra [5] = '{19, 61, 1, 10, 7};
        int rb [5] = '{28, 39, 6, 17, 41};
        int n;
        logic [319:0] r;
        n = (nr > 12) ? 12 : nr;
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64 * k -: 64];
        for (int i = 12 - n; i < 12; i++) begin
            x[2] = x[2] ^ 64'((15 - i) * 16 + i);
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int k = 0; k < 5; k++) t[k] = x[k] ^ (~x[(k + 1) % 5] & x[(k + 2) % 5]);
            for (int k = 0; k < 5; k++) x[k] = t[k];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            for (int k = 0; k < 5; k++) x[k] = x[k] ^ rotr(x[k], ra[k]) ^ rotr(x[k], rb[k]);
        end
        for (int k = 0; k < 5; k++) r[319 - 64 * k -: 64] = x[k];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [319:0] st;
        int           lat;
        int           acc;
    } exp_t;

    exp_t         q [2][$];
    bit           seen [2] = '{1'b0, 1'b0};
    logic [319:0] held [2];
    int           stall [2] = '{0, 0};
    int           stall_req = 0;

    // Monitor: check handshake invariants, pop/compare on first out_valid,
    // check hold stability, and choose out_ready for the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ready_vs_busy_%0d", d), {319'd0, ir[d]}, {319'd0, ~bz[d]});
                if (ov[d]) begin
                    chk($sformatf("busy_in_done_%0d", d), {319'd0, bz[d]}, 320'd1);
                    if (!seen[d]) begin
                        if (q[d].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_output_%0d: got out_valid=1 required no pending result", d);
                        end else begin
                            e = q[d].pop_front();
                            chk($sformatf("latency_%0d", d), 320'(cyc - e.acc), 320'(e.lat));
                            chk($sformatf("result_%0d", d), os[d], e.st);
                        end
                        seen[d]  = 1'b1;
                        held[d]  = os[d];
                        stall[d] = stall_req;
                    end else begin
                        chk($sformatf("hold_stable_%0d", d), os[d], held[d]);
                    end
                    if (stall[d] > 0) begin
                        ordy[d] = 1'b0;
                        stall[d]--;
                    end else begin
                        ordy[d] = ($urandom_range(0, 3) != 0);
                    end
                    if (ordy[d]) seen[d] = 1'b0;
                end else begin
                    ordy[d] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int k = 0; k < 10; k++) s[32 * k +: 32] = $urandom;
        return s;
    endfunction

    task automatic issue(input logic [319:0] st, input int nr);
        int n;
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!(ir[0] && ir[1]) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got in_ready=%b%b required 11", ir[0], ir[1]);
        end else begin
            n = (nr > 12) ? 12 : nr;
            in_valid  = 1'b1;
            in_state  = st;
            in_rounds = 4'(nr);
            e.st  = model_perm(st, nr);
            e.acc = cyc;
            e.lat = (n == 0) ? 1 : n + 1;
            q[0].push_back(e);
            e.lat = (n == 0) ? 1 : (n + 1) / 2 + 1;
            q[1].push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(q[0].size() == 0 && q[1].size() == 0 && ir[0] && ir[1]) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got pending=%0d/%0d required 0/0", q[0].size(), q[1].size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_in_ready_%0d", tag, d), {319'd0, ir[d]}, 320'd1);
            chk($sformatf("%s_out_valid_%0d", tag, d), {319'd0, ov[d]}, 320'd0);
            chk($sformatf("%s_busy_%0d", tag, d), {319'd0, bz[d]}, 320'd0);
            chk($sformatf("%s_out_state_%0d", tag, d), os[d], 320'd0);
        end
    endtask

    task automatic clear_scoreboard();
        for (int d = 0; d < 2; d++) begin
            q[d].delete();
            seen[d]  = 1'b0;
            stall[d] = 0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_rounds = 4'd0;
        in_state  = 320'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // zero-state p12 with a 5-cycle stall and ignored in_valid pulses
        stall_req = 5;
        issue(320'd0, 12);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!ir[0] && !ir[1]) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_state  = rand_state();
                in_rounds = 4'($urandom_range(0, 15));
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        wait_idle();
        stall_req = 0;

        // clamp, odd count, zero rounds and small counts
        issue(320'd0, 15);
        wait_idle();
        issue(rand_state(), 7);
        issue(rand_state(), 15);
        issue(rand_state(), 0);
        issue(rand_state(), 1);
        issue(rand_state(), 2);
        issue(rand_state(), 11);
        wait_idle();

        // randomized requests and back-pressure
        for (int r = 0; r < 40; r++) begin
            stall_req = $urandom_range(0, 3);
            issue(rand_state(), $urandom_range(0, 15));
        end
        wait_idle();
        stall_req = 0;

        // reset during the third RUN cycle of a 12-round request
        issue(rand_state(), 12);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        clear_scoreboard();
        repeat (2) @(negedge clk);
        check_reset_outputs("abort_hold");
        rst = 1'b0;
        issue(rand_state(), 6);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
